vram_word_fetcher: RTL and testbench
====================================

# vram_word_fetcher

Sequential read engine for port B (1024 × 16-bit) of the dual-port video RAM. Software or the video timing logic writes through the 8-bit port A. On a start pulse this block streams a programmed run of 16-bit words from a base address into a small FIFO. It presents the words to the downstream pixel/line-buffer logic over a valid/ready handshake, with credit-based flow control so the FIFO never overflows.

## Interface
Parameters:
- FIFO_DEPTH, 4: output FIFO entries; legal values 4, 8 or 16.
- ADDR_W, 10: RAM word-address width.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock; also drives RAM port B (CLKB).
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; ignored unless the block is idle.
- abort  in  1  synchronous cancel of the current run.
- base_addr  in  ADDR_W  first word address, sampled on start.
- word_count  in  ADDR_W+1  number of words, sampled on start.
- busy  out  1  high from the cycle after an accepted start until done or abort.
- done  out  1  one-cycle pulse after the last word has been popped.
- ram_en  out  1  RAM port B enable (ENB).
- ram_addr  out  ADDR_W  RAM port B address (ADDRB).
- ram_rdata  in  16  RAM port B data (DOB); one-cycle synchronous read.
- out_data  out  16  FIFO head word.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data when this and out_valid are high.
- underrun_cnt  out  8  present only with FETCH_UNDERRUN_CNT_EN.

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE, start=1:
  - word_count=0 → done pulses next cycle, state stays IDLE, no reads.
  - otherwise → FETCH; addr_q=base_addr, remaining=word_count.
- FETCH:
  - Issue a read (ram_en=1, ram_addr=addr_q) when remaining≠0 and fifo_count + inflight < FIFO_DEPTH.
  - fifo_count and inflight are both taken at the start of the cycle; same-cycle pops are not credited.
  - Each issue: addr_q increments mod 2^ADDR_W (1023→0 wraps), remaining decrements.
  - After the last issue → DRAIN.
- inflight: 0–2 (issue register stage plus RAM stage). A word is written into the FIFO when its read data returns.
- DRAIN: when inflight=0, FIFO empty, and no pop this cycle → done=1 for one cycle, state → IDLE.
- word_count > 1024: addresses wrap and words repeat; all word_count words are still delivered.
- abort (any state, priority over start):
  - next cycle: state IDLE, FIFO flushed, inflight data discarded, busy=0, done not pulsed.
  - start in the same cycle as abort is ignored.
- start while busy: ignored; base_addr and word_count are not resampled.
- FIFO push and pop in the same cycle: fifo_count unchanged. The FIFO never overflows by construction.

## Timing
- Reset values: state IDLE, busy=0, done=0, ram_en=0, ram_addr=0, out_valid=0, out_data=0, FIFO empty, inflight=0, underrun_cnt=0.
- ram_en and ram_addr are registered. start sampled at edge E0 → ram_en=1 with ram_addr=base in the cycle after E0 → data written into the FIFO at E2 → out_valid=1 in the cycle after E2. Latency from start to first valid is 3 clocks.
- With out_ready held high and FIFO_DEPTH≥4, steady-state throughput is 1 word/clock.
- busy rises the cycle after start is accepted and falls in the same cycle done is high.
- out_data is stable while out_valid=1 and out_ready=0.

## Configuration
- FETCH_UNDERRUN_CNT_EN defined:
  - adds underrun_cnt, an 8-bit counter saturating at 255.
  - increments each cycle that busy=1, out_ready=1 and out_valid=0.
  - cleared by reset and by an accepted start.
- Not defined: no port, no counter logic.

## Structure
- Shared package (aqms video): state enum fetch_state_t {IDLE, FETCH, DRAIN}, VRAM_WORD_ADDR_W=10, VRAM_WORD_W=16.
- One sub-module: sync_fifo (parameterised width/depth, registered head, count output), instantiated for the output FIFO.
- Top level holds the FSM, the address/remaining counters, the inflight tracking and the optional counter.

## Test plan
- Basic run: base=0x010, count=4, RAM[0x010..0x013]=0x1111,0x2222,0x3333,0x4444, out_ready=1 → out_valid 3 clocks after start, words in that order on consecutive cycles, done pulses once, busy falls with done.
- Zero length: count=0 → done the next cycle, ram_en never asserted, busy stays 0.
- Wrap: base=0x3FE, count=4 → ram_addr 0x3FE, 0x3FF, 0x000, 0x001; the four words are delivered in that order.
- Backpressure: count=16, out_ready=0 for 20 cycles → fifo_count reaches FIFO_DEPTH, ram_en stays 0 while full, no word lost or duplicated after out_ready=1.
- Abort mid-run: count=100, abort at the 10th pop → out_valid=0 next cycle, no done, and a new start (base=0x200, count=2) delivers only the RAM[0x200..0x201] words.
- Reset mid-run: reset asserted asynchronously during FETCH → all outputs take reset values immediately. With FETCH_UNDERRUN_CNT_EN, holding out_ready=1 through the 3-clock start latency gives underrun_cnt=2 after one run.

Source files
------------

// File: rtl/vram_word_fetcher_pkg.sv
// Shared video-RAM types for the port-B fetch path: word geometry and fetch FSM states.
package vram_word_fetcher_pkg;

  localparam int VRAM_WORD_ADDR_W = 10;
  localparam int VRAM_WORD_W      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/vram_word_fetcher_sync_fifo.sv
// Synchronous FIFO with a registered head word, occupancy count and synchronous flush.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             pop_ok;
  logic             body_to_head;
  logic             push_to_head;
  logic             push_to_body;

  assign valid = (count != '0);

  // The head register holds the oldest word; mem holds everything behind it.
  always_comb begin
    pop_ok       = pop && (count != '0);
    body_to_head = pop_ok && (count > CNT_W'(1));
    push_to_head = push && ((count == '0) || (pop_ok && (count == CNT_W'(1))));
    push_to_body = push && !push_to_head;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head   <= '0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (body_to_head) begin
        head   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end else if (push_to_head) begin
        head <= wdata;
      end
      if (push_to_body) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_to_body && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/vram_word_fetcher.sv
// Port-B sequential word fetcher: streams a run of VRAM words into a credit-limited FIFO.
// Optional FETCH_UNDERRUN_CNT_EN adds an 8-bit saturating consumer-starvation counter.
//
// state | meaning
// IDLE  | waiting for start; no reads outstanding
// FETCH | issuing reads while FIFO credit and remaining words allow
// DRAIN | all reads issued; waiting for pipeline and FIFO to empty
module vram_word_fetcher
  import vram_word_fetcher_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = VRAM_WORD_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [ADDR_W:0]        word_count,
  output logic                   busy,
  output logic                   done,
  output logic                   ram_en,
  output logic [ADDR_W-1:0]      ram_addr,
  input  logic [VRAM_WORD_W-1:0] ram_rdata,
  output logic [VRAM_WORD_W-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready
`ifdef FETCH_UNDERRUN_CNT_EN
  , output logic [7:0]           underrun_cnt
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [ADDR_W-1:0] issue_addr;
  logic              issue;
  logic              rd_pend_q;
  logic              zero_start;
  logic              zero_done_q;
  logic              drain_done;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    credit_used;
  logic              credit_ok;
  logic              pop;

  assign pop = out_valid && out_ready;

  // Credit counts words already queued plus reads in the ENB register and RAM stages.
  assign credit_used = {1'b0, fifo_count} + (CNT_W+1)'(ram_en) + (CNT_W+1)'(rd_pend_q);
  assign credit_ok   = credit_used < (CNT_W+1)'(FIFO_DEPTH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    issue      = 1'b0;
    issue_addr = addr_q;
    zero_start = 1'b0;
    drain_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count == '0) begin
            zero_start = 1'b1;
          end else begin
            issue      = 1'b1;
            issue_addr = base_addr;
            addr_d     = base_addr + 1'b1;
            rem_d      = word_count - 1'b1;
            state_d    = (word_count == (ADDR_W+1)'(1)) ? DRAIN : FETCH;
          end
        end
      end
      FETCH: begin
        if ((rem_q != '0) && credit_ok) begin
          issue  = 1'b1;
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == (ADDR_W+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!ram_en && !rd_pend_q && !out_valid) begin
          drain_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d    = IDLE;
      issue      = 1'b0;
      zero_start = 1'b0;
      drain_done = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      rem_q       <= '0;
      ram_en      <= 1'b0;
      ram_addr    <= '0;
      rd_pend_q   <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      ram_en      <= issue;
      if (issue) ram_addr <= issue_addr;
      rd_pend_q   <= ram_en && !abort;
      zero_done_q <= zero_start;
    end
  end

  // busy drops in the same cycle the completion pulse is shown.
  assign done = zero_done_q || drain_done;
  assign busy = (state_q != IDLE) && !drain_done;

  sync_fifo #(
    .WIDTH (VRAM_WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (abort),
    .push  (rd_pend_q),
    .wdata (ram_rdata),
    .pop   (pop),
    .head  (out_data),
    .valid (out_valid),
    .count (fifo_count)
  );

`ifdef FETCH_UNDERRUN_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrun_cnt <= '0;
    end else if (start && !abort && (state_q == IDLE)) begin
      underrun_cnt <= '0;
    end else if (busy && out_ready && !out_valid && (underrun_cnt != 8'hFF)) begin
      underrun_cnt <= underrun_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vram_word_fetcher.sv
// Directed bench for vram_word_fetcher with a behavioural port-B RAM model.
module tb_vram_word_fetcher;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [10:0] word_count = '0;
  logic        busy, done, ram_en, out_valid;
  logic [9:0]  ram_addr;
  logic [15:0] ram_rdata = '0;
  logic [15:0] out_data;
`ifdef FETCH_UNDERRUN_CNT_EN
  logic [7:0]  underrun_cnt;
`endif

  logic [15:0] vmem [1024];
  logic [15:0] dq [$];
  logic [9:0]  aq [$];
  int          done_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  vram_word_fetcher dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .ram_en     (ram_en),
    .ram_addr   (ram_addr),
    .ram_rdata  (ram_rdata),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef FETCH_UNDERRUN_CNT_EN
    , .underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_en) ram_rdata <= vmem[ram_addr];

  always @(posedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) dq.push_back(out_data);
      if (ram_en) aq.push_back(ram_addr);
      if (done) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    chk(tag, done, 1);
  endtask

  task automatic pulse_start(input logic [9:0] b, input logic [10:0] c);
    base_addr  = b;
    word_count = c;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [9:0]  wa [4];
    logic [15:0] wd [4];
    int          k;
    int          n0;
    int          d0;

    for (int i = 0; i < 1024; i++) vmem[i] = 16'hC000 | 16'(i);
    vmem[10'h010] = 16'h1111; vmem[10'h011] = 16'h2222;
    vmem[10'h012] = 16'h3333; vmem[10'h013] = 16'h4444;
    vmem[10'h3FE] = 16'hA0FE; vmem[10'h3FF] = 16'hA0FF;
    vmem[10'h000] = 16'hA000; vmem[10'h001] = 16'hA001;
    for (int i = 0; i < 16; i++) vmem[10'h100 + i] = 16'hB000 + 16'(i);
    vmem[10'h200] = 16'hD200; vmem[10'h201] = 16'hD201;

    // reset values
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
`ifdef FETCH_UNDERRUN_CNT_EN
    chk("rst_underrun", underrun_cnt, 0);
`endif
    @(posedge clk);
    #1 reset = 1'b0;
    tick();

    // basic run, 3-clock latency, back-to-back words
    out_ready = 1'b1;
    dq.delete(); aq.delete();
    pulse_start(10'h010, 11'd4);
    chk("basic_busy", busy, 1);
    chk("basic_ram_en", ram_en, 1);
    chk("basic_ram_addr", ram_addr, 10'h010);
    chk("basic_valid_c1", out_valid, 0);
    tick();
    chk("basic_valid_c2", out_valid, 0);
    tick();
    chk("basic_valid_c3", out_valid, 1);
    chk("basic_w0", out_data, 16'h1111);
    tick();
    chk("basic_w1", out_data, 16'h2222);
    tick();
    chk("basic_w2", out_data, 16'h3333);
    tick();
    chk("basic_w3", out_data, 16'h4444);
    chk("basic_busy_last", busy, 1);
    tick();
    chk("basic_done", done, 1);
    chk("basic_busy_fall", busy, 0);
    chk("basic_valid_end", out_valid, 0);
`ifdef FETCH_UNDERRUN_CNT_EN
    chk("basic_underrun", underrun_cnt, 2);
`endif
    tick();
    chk("basic_done_once", done, 0);
    chk("basic_done_cnt", done_cnt, 1);
    chk("basic_words", dq.size(), 4);

    // zero length
    n0 = aq.size();
    pulse_start(10'h055, 11'd0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_ram_en", ram_en, 0);
    tick();
    chk("zero_done_pulse", done, 0);
    chk("zero_busy2", busy, 0);
    chk("zero_no_reads", aq.size(), n0);

    // address wrap
    wa = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    wd = '{16'hA0FE, 16'hA0FF, 16'hA000, 16'hA001};
    dq.delete(); aq.delete();
    pulse_start(10'h3FE, 11'd4);
    wait_done("wrap_done", 40);
    tick();
    chk("wrap_nreads", aq.size(), 4);
    chk("wrap_nwords", dq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wrap_addr%0d", i), aq[i], wa[i]);
      chk($sformatf("wrap_data%0d", i), dq[i], wd[i]);
    end

    // backpressure, plus a start while busy that must be ignored
    out_ready = 1'b0;
    dq.delete(); aq.delete();
    pulse_start(10'h100, 11'd16);
    tick(19);
    chk("bp_issues_full", aq.size(), 4);
    chk("bp_ram_en_idle", ram_en, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_head", out_data, 16'hB000);
    pulse_start(10'h003, 11'd1);
    chk("bp_head_stable", out_data, 16'hB000);
    chk("bp_still_busy", busy, 1);
    out_ready = 1'b1;
    wait_done("bp_done", 100);
    tick();
    chk("bp_nwords", dq.size(), 16);
    chk("bp_nreads", aq.size(), 16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("bp_data%0d", i), dq[i], 16'hB000 + 16'(i));

    // abort on the 10th pop
    dq.delete();
    d0 = done_cnt;
    pulse_start(10'h000, 11'd100);
    k = 0;
    while (dq.size() < 9 && k < 50) begin
      tick();
      k++;
    end
    chk("abort_reach9", dq.size(), 9);
    chk("abort_valid_pre", out_valid, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_npop", dq.size(), 10);
    chk("abort_w9", dq[9], 16'hC009);
    tick(3);
    chk("abort_valid_later", out_valid, 0);
    chk("abort_no_done", done_cnt, d0);
    dq.delete();
    pulse_start(10'h200, 11'd2);
    wait_done("abort_restart_done", 40);
    tick();
    chk("abort_restart_n", dq.size(), 2);
    chk("abort_restart_w0", dq[0], 16'hD200);
    chk("abort_restart_w1", dq[1], 16'hD201);

    // asynchronous reset mid-run
    pulse_start(10'h000, 11'd8);
    tick(2);
    #2 reset = 1'b1;
    #1;
    chk("amid_busy", busy, 0);
    chk("amid_done", done, 0);
    chk("amid_ram_en", ram_en, 0);
    chk("amid_ram_addr", ram_addr, 0);
    chk("amid_valid", out_valid, 0);
    chk("amid_data", out_data, 0);
`ifdef FETCH_UNDERRUN_CNT_EN
    chk("amid_underrun", underrun_cnt, 0);
`endif
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    chk("post_rst_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
